cu_fsm_mc: RTL and testbench

Multi-cycle control unit FSM for the OTTER RISC-V core; next generation of the single-cycle-memory CU. Sequences fetch / execute / writeback / interrupt. Supports parametrised memory wait (fixed-latency counter or ack handshake), SYSTEM/CSR instructions, mret and gated interrupt entry. Sits between IR decode and the PC, register file, memory and CSR write enables.

---
 rtl/otter_cu_pkg.sv | 36 +++
 rtl/cu_fsm_mc_if.sv | 35 +++
 rtl/mem_wait_ctr.sv | 44 ++++
 rtl/cu_fsm_mc.sv | 160 ++++++++++++++++
 tb/tb_cu_fsm_mc.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/otter_cu_pkg.sv
// Shared types and constants for the OTTER multi-cycle control unit.
package otter_cu_pkg;

   // Wide enough for any memory latency the wait counter has to track.
   localparam int CTR_W = $clog2(16);

   typedef enum logic [2:0] {
      st_init = 3'd0,
      st_fet  = 3'd1,
      st_ex   = 3'd2,
      st_wb   = 3'd3,
      st_intr = 3'd4
   } state_type;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_RG3    = 7'b0110011,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   localparam logic [2:0]  F3_PRIV  = 3'b000;
   localparam logic [11:0] F12_MRET = 12'h302;

   // mret is the privileged (funct3 = 0) SYSTEM op with funct12 = 0x302.
   function automatic logic is_mret(input logic [2:0] f3, input logic [11:0] f12);
      return (f3 == F3_PRIV) && (f12 == F12_MRET);
   endfunction

endpackage

// File: rtl/cu_fsm_mc_if.sv
// Decode/handshake bundle between the control unit and the datapath.
interface cu_fsm_mc_if;
   logic        intr;
   logic        csr_mie;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [11:0] funct12;
   logic        mem1_ack;
   logic        mem2_ack;

   logic        PC_WE;
   logic        RF_WE;
   logic        memWE2;
   logic        memRDEN1;
   logic        memRDEN2;
   logic        CSR_WE;
   logic        int_taken;
   logic        mret_exec;
   logic        illegal_op;
   logic        reset;

   // control unit side
   modport master (
      input  intr, csr_mie, opcode, funct3, funct12, mem1_ack, mem2_ack,
      output PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, CSR_WE,
             int_taken, mret_exec, illegal_op, reset
   );

   // datapath side
   modport slave (
      output intr, csr_mie, opcode, funct3, funct12, mem1_ack, mem2_ack,
      input  PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, CSR_WE,
             int_taken, mret_exec, illegal_op, reset
   );
endinterface

// File: rtl/mem_wait_ctr.sv
// Memory wait tracker: fixed-latency counter or ack handshake, chosen by MEM_MODE.
module mem_wait_ctr
   import otter_cu_pkg::*;
#(
   parameter int MEM_MODE = 0,
   parameter int MEM_LAT  = 1
) (
   input  logic clk,
   input  logic RST_N,
   input  logic clear,
   input  logic wait_en,
   input  logic ack_sel,
   input  logic ack1,
   input  logic ack2,
   output logic done
);

   localparam logic [CTR_W-1:0] LAST = CTR_W'(MEM_LAT - 1);

   logic [CTR_W-1:0] cnt;
   logic             ack;

   assign ack = ack_sel ? ack2 : ack1;

   // An ack or terminal count only counts while the FSM is actually waiting.
   always_comb begin
      done = 1'b0;
      if (wait_en) begin
         done = (MEM_MODE == 1) ? ack : (cnt == LAST);
      end
   end

   // Cycle counter: cleared on every state change, saturates so it never wraps.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (wait_en && !done && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cu_fsm_mc.sv
// Multi-cycle OTTER control unit: fetch / execute / writeback / interrupt sequencing.
//
// state   | meaning
// st_init | datapath reset, one cycle after RST_N release
// st_fet  | instruction read, held until the memory wait completes
// st_ex   | decode and execute; loads/stores wait on data memory here
// st_wb   | load writeback
// st_intr | interrupt entry: save mepc, vector the PC
module cu_fsm_mc
   import otter_cu_pkg::*;
#(
   parameter int MEM_MODE = 0,
   parameter int MEM_LAT  = 1,
   parameter int INTR_EN  = 1
) (
   input logic         clk,
   input logic         RST_N,
   cu_fsm_mc_if.master cu
);

   state_type ps, ns;
   state_type ns_bnd;

   logic done, wait_en, ack_sel, clear;
   logic pc_we, rf_we, mem_we2, mem_rden1, mem_rden2, csr_we;
   logic int_taken, mret_exec, illegal_op, dp_reset;
   logic irq_go;

   // Interrupts are only taken at an instruction boundary.
   assign irq_go = (INTR_EN != 0) && cu.intr && cu.csr_mie;
   assign ns_bnd = irq_go ? st_intr : st_fet;
   assign clear  = (ns != ps);

   mem_wait_ctr #(
      .MEM_MODE (MEM_MODE),
      .MEM_LAT  (MEM_LAT)
   ) u_wait (
      .clk     (clk),
      .RST_N   (RST_N),
      .clear   (clear),
      .wait_en (wait_en),
      .ack_sel (ack_sel),
      .ack1    (cu.mem1_ack),
      .ack2    (cu.mem2_ack),
      .done    (done)
   );

   // State register.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         ps <= st_init;
      end else begin
         ps <= ns;
      end
   end

   // Next-state and output decode.
   always_comb begin
      ns         = ps;
      wait_en    = 1'b0;
      ack_sel    = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      mem_we2    = 1'b0;
      mem_rden1  = 1'b0;
      mem_rden2  = 1'b0;
      csr_we     = 1'b0;
      int_taken  = 1'b0;
      mret_exec  = 1'b0;
      illegal_op = 1'b0;
      dp_reset   = 1'b0;

      case (ps)
         st_init: begin
            dp_reset = 1'b1;
            ns       = st_fet;
         end

         st_fet: begin
            mem_rden1 = 1'b1;
            wait_en   = 1'b1;
            if (done) ns = st_ex;
         end

         st_ex: begin
            case (cu.opcode)
               OP_LOAD: begin
                  mem_rden2 = 1'b1;
                  wait_en   = 1'b1;
                  ack_sel   = 1'b1;
                  if (done) ns = st_wb;
               end
               OP_STORE: begin
                  mem_we2 = 1'b1;
                  wait_en = 1'b1;
                  ack_sel = 1'b1;
                  if (done) begin
                     pc_we = 1'b1;
                     ns    = ns_bnd;
                  end
               end
               OP_LUI, OP_AUIPC, OP_IMM, OP_RG3, OP_JAL, OP_JALR: begin
                  pc_we = 1'b1;
                  rf_we = 1'b1;
                  ns    = ns_bnd;
               end
               OP_BRANCH: begin
                  pc_we = 1'b1;
                  ns    = ns_bnd;
               end
               OP_SYSTEM: begin
                  pc_we = 1'b1;
                  if (cu.funct3 != F3_PRIV) begin
                     rf_we  = 1'b1;
                     csr_we = 1'b1;
                     ns     = ns_bnd;
                  end else if (is_mret(cu.funct3, cu.funct12)) begin
                     // mie is still the trap-time value here, so never re-enter.
                     mret_exec = 1'b1;
                     ns        = st_fet;
                  end else begin
                     ns = ns_bnd;
                  end
               end
               default: begin
                  illegal_op = 1'b1;
                  pc_we      = 1'b1;
                  ns         = ns_bnd;
               end
            endcase
         end

         st_wb: begin
            pc_we = 1'b1;
            rf_we = 1'b1;
            ns    = ns_bnd;
         end

         st_intr: begin
            int_taken = 1'b1;
            pc_we     = 1'b1;
            ns        = st_fet;
         end

         default: ns = st_fet;
      endcase
   end

   assign cu.PC_WE      = pc_we;
   assign cu.RF_WE      = rf_we;
   assign cu.memWE2     = mem_we2;
   assign cu.memRDEN1   = mem_rden1;
   assign cu.memRDEN2   = mem_rden2;
   assign cu.CSR_WE     = csr_we;
   assign cu.int_taken  = int_taken;
   assign cu.mret_exec  = mret_exec;
   assign cu.illegal_op = illegal_op;
   assign cu.reset      = dp_reset;

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Bench for cu_fsm_mc: fixed-latency instance (LAT 3, interrupts on) and
// handshake instance (interrupts off), checked per cycle against a
// per-instruction timeline model.
module tb_cu_fsm_mc;

   localparam int LAT0 = 3;

   // output vector: {reset, PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, CSR_WE, int_taken, mret_exec, illegal_op}
   localparam logic [9:0] O_RST  = 10'b10_0000_0000;
   localparam logic [9:0] O_PC   = 10'b01_0000_0000;
   localparam logic [9:0] O_RF   = 10'b00_1000_0000;
   localparam logic [9:0] O_WE2  = 10'b00_0100_0000;
   localparam logic [9:0] O_RD1  = 10'b00_0010_0000;
   localparam logic [9:0] O_RD2  = 10'b00_0001_0000;
   localparam logic [9:0] O_CSR  = 10'b00_0000_1000;
   localparam logic [9:0] O_INT  = 10'b00_0000_0100;
   localparam logic [9:0] O_MRET = 10'b00_0000_0010;
   localparam logic [9:0] O_ILL  = 10'b00_0000_0001;

   localparam logic [6:0] B_LUI = 7'b0110111, B_AUIPC = 7'b0010111, B_JAL = 7'b1101111;
   localparam logic [6:0] B_JALR = 7'b1100111, B_BR = 7'b1100011, B_LOAD = 7'b0000011;
   localparam logic [6:0] B_STORE = 7'b0100011, B_IMM = 7'b0010011, B_RG3 = 7'b0110011;
   localparam logic [6:0] B_SYS = 7'b1110011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n0, rst_n1;

   cu_fsm_mc_if if0 ();
   cu_fsm_mc_if if1 ();

   cu_fsm_mc #(.MEM_MODE(0), .MEM_LAT(LAT0), .INTR_EN(1)) dut0 (
      .clk(clk), .RST_N(rst_n0), .cu(if0)
   );
   cu_fsm_mc #(.MEM_MODE(1), .MEM_LAT(1), .INTR_EN(0)) dut1 (
      .clk(clk), .RST_N(rst_n1), .cu(if1)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [9:0] exp_q [$];
   bit         a1_q  [$];
   bit         a2_q  [$];

   function automatic bit rbit();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic logic [9:0] outs(input int sel);
      if (sel == 0)
         return {if0.reset, if0.PC_WE, if0.RF_WE, if0.memWE2, if0.memRDEN1, if0.memRDEN2,
                 if0.CSR_WE, if0.int_taken, if0.mret_exec, if0.illegal_op};
      return {if1.reset, if1.PC_WE, if1.RF_WE, if1.memWE2, if1.memRDEN1, if1.memRDEN2,
              if1.CSR_WE, if1.int_taken, if1.mret_exec, if1.illegal_op};
   endfunction

   function automatic logic [6:0] op_of(input int p);
      case (p)
         0: return B_LUI;   1: return B_AUIPC; 2: return B_JAL;  3: return B_JALR;
         4: return B_BR;    5: return B_LOAD;  6: return B_STORE; 7: return B_IMM;
         8: return B_RG3;   9: return B_SYS;   10: return B_SYS; 11: return 7'b1111111;
         default: return 7'($urandom);
      endcase
   endfunction

   task automatic check(input int sel, input logic [9:0] exp, input string tag);
      logic [9:0] obs;
      obs = outs(sel);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s dut%0d: observed %b expected %b", tag, sel, obs, exp);
   endtask

   task automatic set_instr(input int sel, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [11:0] f12, input logic irq, input logic mie);
      if (sel == 0) begin
         if0.opcode = opc; if0.funct3 = f3; if0.funct12 = f12; if0.intr = irq; if0.csr_mie = mie;
      end else begin
         if1.opcode = opc; if1.funct3 = f3; if1.funct12 = f12; if1.intr = irq; if1.csr_mie = mie;
      end
   endtask

   task automatic set_acks(input int sel, input bit a1, input bit a2);
      if (sel == 0) begin
         if0.mem1_ack = a1; if0.mem2_ack = a2;
      end else begin
         if1.mem1_ack = a1; if1.mem2_ack = a2;
      end
   endtask

   task automatic push(input logic [9:0] e, input bit a1, input bit a2);
      exp_q.push_back(e);
      a1_q.push_back(a1);
      a2_q.push_back(a2);
   endtask

   // Build the expected cycle timeline of one instruction, then play it.
   // In handshake mode the ack for a wait comes on its last cycle, earlier
   // cycles hold it low, and the unrelated ack carries random noise.
   task automatic run_instr(input int sel, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [11:0] f12, input logic irq, input logic mie,
                            input int d1, input int d2, input string tag);
      int n1, n2;
      bit hs, no_irq;
      hs     = (sel == 1);
      n1     = hs ? d1 : LAT0;
      n2     = hs ? d2 : LAT0;
      no_irq = 1'b0;
      exp_q.delete(); a1_q.delete(); a2_q.delete();

      for (int k = 0; k < n1; k++)
         push(O_RD1, hs ? (k == n1 - 1) : rbit(), rbit());

      if (opc == B_LOAD) begin
         for (int k = 0; k < n2; k++)
            push(O_RD2, rbit(), hs ? (k == n2 - 1) : rbit());
         push(O_PC | O_RF, rbit(), rbit());
      end else if (opc == B_STORE) begin
         for (int k = 0; k < n2; k++)
            push(O_WE2 | ((k == n2 - 1) ? O_PC : 10'h0), rbit(), hs ? (k == n2 - 1) : rbit());
      end else if (opc == B_LUI || opc == B_AUIPC || opc == B_IMM || opc == B_RG3 ||
                   opc == B_JAL || opc == B_JALR) begin
         push(O_PC | O_RF, rbit(), rbit());
      end else if (opc == B_BR) begin
         push(O_PC, rbit(), rbit());
      end else if (opc == B_SYS) begin
         if (f3 != 3'b000) begin
            push(O_PC | O_RF | O_CSR, rbit(), rbit());
         end else if (f12 == 12'h302) begin
            push(O_PC | O_MRET, rbit(), rbit());
            no_irq = 1'b1;
         end else begin
            push(O_PC, rbit(), rbit());
         end
      end else begin
         push(O_PC | O_ILL, rbit(), rbit());
      end

      if (!hs && irq && mie && !no_irq)
         push(O_PC | O_INT, rbit(), rbit());

      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         if (i == 0) set_instr(sel, opc, f3, f12, irq, mie);
         set_acks(sel, a1_q[i], a2_q[i]);
         #1;
         check(sel, exp_q[i], $sformatf("%s[%0d]", tag, i));
      end
   endtask

   task automatic rand_run(input int sel, input int count);
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [11:0] f12;
      for (int i = 0; i < count; i++) begin
         opc = op_of($urandom_range(0, 12));
         f3  = rbit() ? 3'b000 : 3'($urandom);
         f12 = rbit() ? 12'h302 : 12'($urandom);
         run_instr(sel, opc, f3, f12, rbit(), rbit(),
                   $urandom_range(1, 5), $urandom_range(1, 5), $sformatf("rnd%0d", i));
      end
   endtask

   initial begin
      rst_n0 = 1'b0;
      rst_n1 = 1'b0;
      set_instr(0, 7'h0, 3'h0, 12'h0, 1'b0, 1'b0);
      set_instr(1, 7'h0, 3'h0, 12'h0, 1'b0, 1'b0);
      set_acks(0, 1'b0, 1'b0);
      set_acks(1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      #1;
      check(0, O_RST, "reset0");
      check(1, O_RST, "reset1");

      // fixed-latency instance
      @(negedge clk);
      rst_n0 = 1'b1;
      #1 check(0, O_RST, "init0");
      run_instr(0, B_IMM,   3'h0, 12'h0,   1'b0, 1'b0, 0, 0, "op_imm");
      run_instr(0, B_RG3,   3'h0, 12'h0,   1'b1, 1'b1, 0, 0, "op_rg3_irq");
      run_instr(0, B_RG3,   3'h0, 12'h0,   1'b1, 1'b0, 0, 0, "op_rg3_mie0");
      run_instr(0, B_SYS,   3'h0, 12'h302, 1'b1, 1'b1, 0, 0, "mret");
      run_instr(0, B_SYS,   3'h1, 12'h0,   1'b0, 1'b0, 0, 0, "csrrw");
      run_instr(0, B_SYS,   3'h0, 12'h000, 1'b0, 1'b1, 0, 0, "ecall");
      run_instr(0, 7'h7f,   3'h0, 12'h0,   1'b0, 1'b0, 0, 0, "illegal");
      run_instr(0, B_STORE, 3'h2, 12'h0,   1'b0, 1'b0, 0, 0, "store");
      run_instr(0, B_LOAD,  3'h2, 12'h0,   1'b1, 1'b1, 0, 0, "load_irq");
      run_instr(0, B_BR,    3'h0, 12'h0,   1'b0, 1'b0, 0, 0, "branch");

      // asynchronous reset in the middle of a fetch wait
      @(negedge clk);
      set_instr(0, B_IMM, 3'h0, 12'h0, 1'b0, 1'b0);
      #1 check(0, O_RD1, "pre_rst_fet0");
      @(negedge clk);
      #1 check(0, O_RD1, "pre_rst_fet1");
      #1 rst_n0 = 1'b0;
      #1 check(0, O_RST, "async_rst");
      @(posedge clk);
      #1 check(0, O_RST, "rst_held");
      @(negedge clk);
      rst_n0 = 1'b1;
      #1 check(0, O_RST, "init_after_rst");
      run_instr(0, B_IMM, 3'h0, 12'h0, 1'b0, 1'b0, 0, 0, "post_rst");

      rand_run(0, 40);

      // handshake instance
      @(negedge clk);
      rst_n1 = 1'b1;
      #1 check(1, O_RST, "init1");
      run_instr(1, B_LOAD,  3'h2, 12'h0, 1'b0, 1'b0, 2, 4, "load_ack4");
      run_instr(1, B_RG3,   3'h0, 12'h0, 1'b1, 1'b1, 1, 1, "no_intr_en");
      run_instr(1, B_STORE, 3'h2, 12'h0, 1'b1, 1'b1, 3, 2, "store_ack2");
      rand_run(1, 40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
